ifetch_ctrl: RTL and testbench
==============================

// Module: ifetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the word-addressed, combinational-read instruction ROM.
//  Owns the PC and drives the ROM address. Buffers fetched words in a small FIFO and presents
//  them to decode with a valid/ready handshake.
//  Handles branch/jump redirects, decode back-pressure and end-of-program halt.
//  Sits between the ROM and the decode/register/immediate stage.
// PARAMETERS
//  RESET_PC   0   word address of the first instruction fetched after reset
//  MEM_WORDS  82  ROM depth in words; legal PC range is 0..MEM_WORDS-1
//  BUF_DEPTH  2   fetch FIFO entries; power of 2, >=2
//  NOP_WORD   32'h00000000  word presented on id_ins when id_valid=0
// PORTS
//  clk             in   1   rising-edge clock
//  rst             in   1   synchronous, active-high reset
//  imem_addr       out  32  word address to ROM (ROM returns the word in the same cycle)
//  imem_ins        in   32  instruction word from ROM
//  redirect_valid  in   1   branch/jump taken; flush and restart fetch
//  redirect_pc     in   32  new word address, sampled when redirect_valid=1
//  id_ready        in   1   decode accepts the head entry this cycle
//  id_valid        out  1   head entry valid
//  id_ins          out  32  head instruction (NOP_WORD when id_valid=0)
//  id_pc           out  32  word address of the head instruction (0 when id_valid=0)
//  halt            out  1   fetch stopped and FIFO empty
//  fetch_cnt       out  32  [IFETCH_PERF_EN only] words written into the FIFO
//  stall_cnt       out  32  [IFETCH_PERF_EN only] cycles with id_valid=1 and id_ready=0
// BEHAVIOUR
//  - Reset (rst=1 at posedge, including mid-operation):
//      pc=RESET_PC, FIFO count=0, state=BOOT, id_valid=0, id_ins=NOP_WORD, id_pc=0, halt=0.
//  - FSM states:
//      BOOT -> RUN after 1 cycle; no fetch in BOOT.
//      RUN -> HALT when pc>=MEM_WORDS at a fetch opportunity, or when redirect_pc>=MEM_WORDS.
//      HALT -> RUN on redirect_valid with redirect_pc<MEM_WORDS.
//  - imem_addr = pc, continuously.
//  - Fetch (RUN only):
//      Occurs when pc<MEM_WORDS, no redirect, and (count<BUF_DEPTH or pop this cycle).
//      Writes {imem_ins, pc} to the FIFO tail; pc <= pc+1 (32-bit wrap).
//  - Pop: id_valid & id_ready. Head advances; a simultaneous push and pop leaves count unchanged.
//  - Latency: the first id_valid comes 2 cycles after rst deasserts (BOOT, then a fetch).
//    Steady state is 1 instruction/cycle with id_ready=1.
//  - Full (count=BUF_DEPTH, no pop): no fetch, pc holds. No word is lost or duplicated.
//  - Empty: id_valid=0, id_ins=NOP_WORD, id_pc=0.
//  - Redirect (highest priority, any state except BOOT):
//      Next cycle: count=0 and pc=redirect_pc; no push this cycle.
//      A pop in the same cycle still counts as accepted by decode.
//      The first redirected word reaches id_* 1 cycle later.
//  - halt = (state==HALT) & (count==0). Remaining buffered words drain normally in HALT.
//  - Redirect during BOOT is ignored.
//  - FIFO pointers are log2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH.
//    count is log2(BUF_DEPTH)+1 bits.
// CONFIGURATION
//  IFETCH_PERF_EN:
//    Defined: fetch_cnt and stall_cnt ports exist. Both reset to 0, increment per event,
//    wrap at 2^32, and are not cleared by redirect.
//    Undefined: both ports and their counters are absent; all other behaviour is identical.
// TESTING
//  T1 rst 2 cycles, RESET_PC=0, id_ready=1
//     -> id_valid rises cycle 2; id_pc=0,1,2,3... one per cycle; id_ins==ROM[id_pc].
//  T2 id_ready=0 for 5 cycles after first valid
//     -> count saturates at 2; imem_addr holds at 2; on release id_pc continues 0,1,2 with no gap or duplicate.
//  T3 FIFO full (id_pc 4,5 held), redirect_valid=1 redirect_pc=12
//     -> next valid id_pc=12, id_ins=ROM[12]; 4/5 never reappear.
//  T4 MEM_WORDS=32, id_ready=1 from reset
//     -> after id_pc=31 accepted, halt=1 and id_valid=0;
//        redirect_pc=5 -> halt=0, id_pc=5 two cycles later;
//        redirect_pc=40 -> halt=1 immediately once FIFO is empty.
//  T5 rst pulsed 1 cycle with FIFO full mid-stream
//     -> following cycle id_valid=0, id_pc=0, imem_addr=RESET_PC, halt=0; fetch restarts at RESET_PC.
//  T6 IFETCH_PERF_EN: 10 accepted fetches with 3 back-pressure cycles
//     -> stall_cnt=3; fetch_cnt equals number of FIFO pushes (checked against scoreboard).

Source files
------------

// File: rtl/ifetch_ctrl.sv
// ----------------------------------------------------------------------------
// ifetch_ctrl
//   Instruction-fetch sequencer for a word-addressed, combinational-read ROM.
//   Owns the PC, drives the ROM address, buffers fetched words in a small
//   FIFO and presents them to decode with a valid/ready handshake. Handles
//   redirects (flush + restart), decode back-pressure and end-of-program halt.
//
//   Optional feature macro: IFETCH_PERF_EN
//     When defined, adds the fetch_cnt / stall_cnt performance counters and
//     their output ports. When undefined, both are absent.
// ----------------------------------------------------------------------------
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_WORDS = 82,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_ins,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc,
    output logic        halt
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned    PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned    CNT_W     = PTR_W + 1;
    localparam logic [31:0]    MEM_LIMIT = 32'(MEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [31:0]      r_pc;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_buf_ins [BUF_DEPTH];
    logic [31:0]      r_buf_pc  [BUF_DEPTH];

    logic             w_not_empty;
    logic             w_pop;
    logic             w_redirect;
    logic             w_pc_in_range;
    logic             w_redir_in_range;
    logic             w_has_room;
    logic             w_fetch;

    // Handshake and fetch-qualification terms shared by FSM and datapath.
    always_comb begin
        w_not_empty      = (r_count != CNT_ZERO);
        w_pop            = w_not_empty & id_ready;
        // Redirects are meaningless before the first fetch, so BOOT drops them.
        w_redirect       = redirect_valid & (r_state != ST_BOOT);
        w_pc_in_range    = (r_pc < MEM_LIMIT);
        w_redir_in_range = (redirect_pc < MEM_LIMIT);
        // A pop in the same cycle frees a slot, allowing full-rate streaming.
        w_has_room       = (r_count < CNT_FULL) | w_pop;
        w_fetch          = (r_state == ST_RUN) & w_pc_in_range & ~w_redirect & w_has_room;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: redirect target decides RUN/HALT, running off the ROM halts.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_redirect) begin
                    if (w_redir_in_range) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_HALT;
                    end
                end else if (!w_pc_in_range) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                if (w_redirect && w_redir_in_range) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // PC, FIFO pointers and occupancy; a redirect flushes the FIFO and reloads the PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= PTR_ZERO;
            r_wr_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else if (w_redirect) begin
            r_pc     <= redirect_pc;
            r_rd_ptr <= PTR_ZERO;
            r_wr_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else begin
            if (w_fetch) begin
                r_pc     <= r_pc + 32'd1;
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_fetch, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: capture the ROM word and its address at the tail on each fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                r_buf_ins[i] <= NOP_WORD;
                r_buf_pc[i]  <= 32'd0;
            end
        end else if (w_fetch) begin
            r_buf_ins[r_wr_ptr] <= imem_ins;
            r_buf_pc[r_wr_ptr]  <= r_pc;
        end else begin
            r_buf_ins[r_wr_ptr] <= r_buf_ins[r_wr_ptr];
            r_buf_pc[r_wr_ptr]  <= r_buf_pc[r_wr_ptr];
        end
    end

    assign imem_addr = r_pc;
    assign id_valid  = w_not_empty;
    assign id_ins    = w_not_empty ? r_buf_ins[r_rd_ptr] : NOP_WORD;
    assign id_pc     = w_not_empty ? r_buf_pc[r_rd_ptr]  : 32'd0;
    assign halt      = (r_state == ST_HALT) & ~w_not_empty;

`ifdef IFETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    // Performance counters: FIFO pushes and decode back-pressure cycles; survive redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_fetch) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_not_empty && !id_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ifetch_ctrl
//   Self-checking bench for ifetch_ctrl (MEM_WORDS=32, BUF_DEPTH=2).
//   A queue-based reference model is stepped on every rising edge and a
//   compare process checks all outputs on every falling edge. Directed
//   sequences pin the model with hand-computed values, then a randomized
//   phase mixes back-pressure, redirects (in and out of range) and resets.
// ----------------------------------------------------------------------------
module tb_ifetch_ctrl;

    localparam int          MW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'd0;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_ins;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_ins;
    logic [31:0] id_pc;
    logic        halt;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    ifetch_ctrl #(
        .RESET_PC (RPC),
        .MEM_WORDS(MW),
        .BUF_DEPTH(DEPTH),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_ins      (imem_ins),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_ins        (id_ins),
        .id_pc         (id_pc),
        .halt          (halt)
`ifdef IFETCH_PERF_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    // ROM contents and combinational read
    logic [31:0] rom [MW];
    assign imem_ins = (imem_addr < 32'(MW)) ? rom[imem_addr[4:0]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_q_pc  [$];
    logic [31:0] m_q_ins [$];
    bit          m_boot;
    bit          m_halted;
    logic [31:0] m_fetches;
    logic [31:0] m_stalls;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock of the behavioural model, from the sampled inputs.
    task automatic model_step();
        bit pop;
        if (rst) begin
            m_q_pc.delete();
            m_q_ins.delete();
            m_pc      = RPC;
            m_boot    = 1'b1;
            m_halted  = 1'b0;
            m_fetches = 32'd0;
            m_stalls  = 32'd0;
        end else begin
            pop = (m_q_pc.size() > 0) && id_ready;
            if ((m_q_pc.size() > 0) && !id_ready) m_stalls = m_stalls + 32'd1;
            if (pop) begin
                void'(m_q_pc.pop_front());
                void'(m_q_ins.pop_front());
            end
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (redirect_valid) begin
                m_q_pc.delete();
                m_q_ins.delete();
                m_pc     = redirect_pc;
                m_halted = (redirect_pc >= 32'(MW));
            end else if (!m_halted) begin
                if (m_pc >= 32'(MW)) begin
                    m_halted = 1'b1;
                end else if (m_q_pc.size() < DEPTH) begin
                    m_q_pc.push_back(m_pc);
                    m_q_ins.push_back(rom[m_pc[4:0]]);
                    m_pc      = m_pc + 32'd1;
                    m_fetches = m_fetches + 32'd1;
                end
            end
        end
    endtask

    // Compare process: every cycle, DUT outputs vs model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("imem_addr", imem_addr, m_pc);
                check("id_valid", {31'd0, id_valid}, (m_q_pc.size() > 0) ? 32'd1 : 32'd0);
                check("id_pc",  id_pc,  (m_q_pc.size() > 0) ? m_q_pc[0]  : 32'd0);
                check("id_ins", id_ins, (m_q_ins.size() > 0) ? m_q_ins[0] : 32'd0);
                check("halt", {31'd0, halt}, (m_halted && m_q_pc.size() == 0) ? 32'd1 : 32'd0);
`ifdef IFETCH_PERF_EN
                check("fetch_cnt", fetch_cnt, m_fetches);
                check("stall_cnt", stall_cnt, m_stalls);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        redirect_valid = 1'b0;
        tick();
        chk_en = 1'b1;
        for (int i = 1; i < n; i++) tick();
        rst = 1'b0;
    endtask

    int b;
    int n_bp;
    int n_acc;

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        id_ready = 1'b1;
        for (int i = 0; i < MW; i++) rom[i] = $urandom;

        // T1: reset state, 2-cycle first-valid latency, one instruction per cycle
        do_reset(2);
        check("rst id_valid", {31'd0, id_valid}, 32'd0);
        check("rst id_pc", id_pc, 32'd0);
        check("rst id_ins", id_ins, 32'd0);
        check("rst halt", {31'd0, halt}, 32'd0);
        check("rst imem_addr", imem_addr, 32'd0);
        tick();
        check("T1 boot no valid", {31'd0, id_valid}, 32'd0);
        tick();
        check("T1 first valid", {31'd0, id_valid}, 32'd1);
        for (int k = 0; k < 7; k++) begin
            check("T1 id_pc seq", id_pc, 32'(k));
            check("T1 id_ins rom", id_ins, rom[k]);
            tick();
        end

        // T2: back-pressure saturates the FIFO, no gap or duplicate on release
        do_reset(2);
        id_ready = 1'b1;
        tick();
        tick();
        id_ready = 1'b0;
        repeat (5) tick();
        check("T2 imem_addr hold", imem_addr, 32'd2);
        check("T2 head held", id_pc, 32'd0);
        id_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("T2 id_pc seq", id_pc, 32'(k));
            tick();
        end

        // T3: full FIFO holding 4,5 flushed by redirect to 12
        do_reset(2);
        id_ready = 1'b1;
        b = 0;
        while (!(id_valid && id_pc == 32'd4) && b < 40) begin tick(); b++; end
        check("T3 reach pc4 in budget", {31'd0, (b < 40)}, 32'd1);
        id_ready = 1'b0;
        tick();
        tick();
        check("T3 full head", id_pc, 32'd4);
        check("T3 full pc", imem_addr, 32'd6);
        redirect_valid = 1'b1;
        redirect_pc = 32'd12;
        tick();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        check("T3 flushed", {31'd0, id_valid}, 32'd0);
        check("T3 new pc", imem_addr, 32'd12);
        tick();
        check("T3 redirected id_pc", id_pc, 32'd12);
        check("T3 redirected id_ins", id_ins, rom[12]);
        tick();
        check("T3 next id_pc", id_pc, 32'd13);

        // T4: run off the end of the ROM, then redirect in and out of range
        do_reset(2);
        id_ready = 1'b1;
        b = 0;
        while (!(id_valid && id_pc == 32'd31) && b < 60) begin tick(); b++; end
        check("T4 reach pc31 in budget", {31'd0, (b < 60)}, 32'd1);
        tick();
        check("T4 halt after last", {31'd0, halt}, 32'd1);
        check("T4 no valid after last", {31'd0, id_valid}, 32'd0);
        tick();
        check("T4 halt holds", {31'd0, halt}, 32'd1);
        check("T4 pc past end", imem_addr, 32'd32);
        redirect_valid = 1'b1;
        redirect_pc = 32'd5;
        tick();
        redirect_valid = 1'b0;
        check("T4 unhalt", {31'd0, halt}, 32'd0);
        tick();
        check("T4 id_pc 5", id_pc, 32'd5);
        redirect_valid = 1'b1;
        redirect_pc = 32'd40;
        tick();
        redirect_valid = 1'b0;
        check("T4 halt on far redirect", {31'd0, halt}, 32'd1);
        check("T4 far pc", imem_addr, 32'd40);

        // Redirect during BOOT is dropped
        do_reset(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'd20;
        tick();
        redirect_valid = 1'b0;
        check("BOOT redirect ignored", imem_addr, 32'd0);
        tick();
        check("BOOT first id_pc", id_pc, 32'd0);

        // T5: reset pulse with FIFO full mid-stream
        do_reset(2);
        id_ready = 1'b1;
        repeat (5) tick();
        id_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        id_ready = 1'b1;
        check("T5 id_valid", {31'd0, id_valid}, 32'd0);
        check("T5 id_pc", id_pc, 32'd0);
        check("T5 imem_addr", imem_addr, 32'd0);
        check("T5 halt", {31'd0, halt}, 32'd0);
        tick();
        tick();
        check("T5 restart id_pc", id_pc, 32'd0);

`ifdef IFETCH_PERF_EN
        // T6: 10 accepted words with exactly 3 back-pressure cycles
        do_reset(2);
        check("T6 fetch_cnt reset", fetch_cnt, 32'd0);
        check("T6 stall_cnt reset", stall_cnt, 32'd0);
        n_acc = 0;
        n_bp = 0;
        b = 0;
        while (n_acc < 10 && b < 100) begin
            if (id_valid && n_bp < 3 && (b % 3 == 1)) begin
                id_ready = 1'b0;
                n_bp++;
            end else begin
                id_ready = 1'b1;
            end
            if (id_valid && id_ready) n_acc++;
            tick();
            b++;
        end
        id_ready = 1'b1;
        check("T6 done in budget", {31'd0, (b < 100)}, 32'd1);
        check("T6 stall_cnt", stall_cnt, 32'd3);
        check("T6 fetch_cnt", fetch_cnt, m_fetches);
`endif

        // Randomized phase: back-pressure, redirects (some beyond ROM), resets
        do_reset(1);
        for (int c = 0; c < 3000; c++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 32'($urandom_range(0, 40));
            rst            = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
